// File: rtl/conv_layer_stream.sv
// Streaming KxK convolution over a raster pixel stream, MAPS output maps, run-time loaded
// weights/biases, three-stage product/sum/saturate pipeline with optional ReLU.
module conv_layer_stream #(
  parameter int IN_WIDTH  = 8,
  parameter int W_WIDTH   = 8,
  parameter int OUT_WIDTH = 32,
  parameter int MAPS      = 6,
  parameter int K         = 5,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int STRIDE    = 1,
  parameter int RELU      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic signed [W_WIDTH-1:0]   load_data,
  input  logic                        en,
  input  logic signed [IN_WIDTH-1:0]  in,
  output logic                        ready,
  output logic [OUT_WIDTH*MAPS-1:0]   out,
  output logic                        out_valid,
  output logic                        frame_done
);

  localparam int KK     = K * K;
  localparam int PW     = IN_WIDTH + W_WIDTH;
  localparam int SW     = PW + $clog2(KK) + 1;
  localparam int BW     = ((SW > OUT_WIDTH) ? SW : OUT_WIDTH) + 1;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int KIW    = $clog2(KK + 1);
  localparam int MIW    = (MAPS > 1) ? $clog2(MAPS) : 1;
  localparam int SPW    = $clog2(STRIDE + 1);
  localparam int LAST_R = IMG_H - 1 - ((IMG_H - K) % STRIDE);
  localparam int LAST_C = IMG_W - 1 - ((IMG_W - K) % STRIDE);

  localparam logic [CW-1:0]  COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [CW-1:0]  COL_K    = CW'(K - 1);
  localparam logic [RW-1:0]  ROW_K    = RW'(K - 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(LAST_C);
  localparam logic [RW-1:0]  ROW_LAST = RW'(LAST_R);
  localparam logic [KIW-1:0] KI_BIAS  = KIW'(KK);
  localparam logic [MIW-1:0] M_LAST   = MIW'(MAPS - 1);
  localparam logic [SPW-1:0] SP_MAX   = SPW'(STRIDE - 1);
  localparam logic signed [BW-1:0] MAXV = {{(BW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [BW-1:0] MINV = ~MAXV;
  localparam bit RELU_ON = (RELU != 0);

  logic                        ready_r;
  logic [MIW-1:0]              ld_m_r, wm_s;
  logic [KIW-1:0]              ld_k_r, wk_s;
  logic signed [W_WIDTH-1:0]   w_r    [MAPS][KK];
  logic signed [W_WIDTH-1:0]   bias_r [MAPS];
  logic [CW-1:0]               col_r;
  logic [RW-1:0]               row_r;
  logic [SPW-1:0]              cph_r, rph_r;
  logic signed [IN_WIDTH-1:0]  lb_r   [K-1][IMG_W];
  logic signed [IN_WIDTH-1:0]  win_r  [K][K];
  logic signed [IN_WIDTH-1:0]  col_s  [K];
  logic                        acc_s, wv_s, wl_s;
  logic                        v0_r, v1_r, v2_r, l0_r, l1_r, l2_r;
  logic signed [PW-1:0]        prod_r [MAPS][KK];
  logic signed [SW-1:0]        sum_s  [MAPS];
  logic signed [SW-1:0]        sum_r  [MAPS];
  logic signed [BW-1:0]        big_s  [MAPS];
  logic signed [OUT_WIDTH-1:0] res_s  [MAPS];
  logic [OUT_WIDTH*MAPS-1:0]   sat_s;
  logic [OUT_WIDTH*MAPS-1:0]   out_r;
  logic                        out_valid_r, frame_done_r;

  // Load address and window qualifiers; a load while ready restarts at word 0
  always_comb begin
    wm_s  = ready_r ? {MIW{1'b0}} : ld_m_r;
    wk_s  = ready_r ? {KIW{1'b0}} : ld_k_r;
    acc_s = en & ready_r & ~load;
    wv_s  = acc_s && (row_r >= ROW_K) && (col_r >= COL_K) &&
            (rph_r == {SPW{1'b0}}) && (cph_r == {SPW{1'b0}});
    wl_s  = (row_r == ROW_LAST) && (col_r == COL_LAST);
  end

  // Coefficient storage
  always_ff @(posedge clk) begin
    if (load) begin
      if (wk_s == KI_BIAS) bias_r[wm_s] <= load_data;
      else                 w_r[wm_s][wk_s] <= load_data;
    end
  end

  // Load sequencing and ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
      ld_m_r  <= {MIW{1'b0}};
      ld_k_r  <= {KIW{1'b0}};
    end else if (load) begin
      if (wk_s == KI_BIAS) begin
        ld_k_r <= {KIW{1'b0}};
        if (wm_s == M_LAST) begin
          ld_m_r  <= {MIW{1'b0}};
          ready_r <= 1'b1;
        end else begin
          ld_m_r  <= wm_s + 1'b1;
          ready_r <= 1'b0;
        end
      end else begin
        ld_k_r  <= wk_s + 1'b1;
        ld_m_r  <= wm_s;
        ready_r <= 1'b0;
      end
    end
  end

  // Raster position and stride phases (phase = (pos-K+1) mod STRIDE once inside the valid area)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
      cph_r <= {SPW{1'b0}};
      rph_r <= {SPW{1'b0}};
    end else if (load) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
      cph_r <= {SPW{1'b0}};
      rph_r <= {SPW{1'b0}};
    end else if (acc_s) begin
      if (col_r == COL_MAX) begin
        col_r <= {CW{1'b0}};
        cph_r <= {SPW{1'b0}};
        if (row_r == ROW_MAX) begin
          row_r <= {RW{1'b0}};
          rph_r <= {SPW{1'b0}};
        end else begin
          row_r <= row_r + 1'b1;
          rph_r <= (row_r < ROW_K || rph_r == SP_MAX) ? {SPW{1'b0}} : rph_r + 1'b1;
        end
      end else begin
        col_r <= col_r + 1'b1;
        cph_r <= (col_r < COL_K || cph_r == SP_MAX) ? {SPW{1'b0}} : cph_r + 1'b1;
      end
    end
  end

  // New window column: K-1 buffered rows above plus the incoming pixel
  always_comb begin
    for (int ky = 0; ky < K - 1; ky++) col_s[ky] = lb_r[ky][col_r];
    col_s[K-1] = in;
  end

  // Line buffer (row 0 oldest) and KxK window shift register
  always_ff @(posedge clk) begin
    if (acc_s) begin
      for (int j = 0; j < K - 2; j++) lb_r[j][col_r] <= lb_r[j+1][col_r];
      lb_r[K-2][col_r] <= in;
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K - 1; kx++) win_r[ky][kx] <= win_r[ky][kx+1];
        win_r[ky][K-1] <= col_s[ky];
      end
    end
  end

  // S1: full-precision products
  always_ff @(posedge clk) begin
    for (int m = 0; m < MAPS; m++)
      for (int i = 0; i < KK; i++)
        prod_r[m][i] <= win_r[i / K][i % K] * w_r[m][i];
  end

  // S2 adder tree input: bias plus all products
  always_comb begin
    for (int m = 0; m < MAPS; m++) begin
      sum_s[m] = SW'(bias_r[m]);
      for (int i = 0; i < KK; i++) sum_s[m] = sum_s[m] + SW'(prod_r[m][i]);
    end
  end

  // S2 register
  always_ff @(posedge clk) begin
    for (int m = 0; m < MAPS; m++) sum_r[m] <= sum_s[m];
  end

  // S3 conditioning: saturate first, then optional ReLU
  always_comb begin
    sat_s = {(OUT_WIDTH*MAPS){1'b0}};
    for (int m = 0; m < MAPS; m++) begin
      big_s[m] = BW'(sum_r[m]);
      if (big_s[m] > MAXV)      res_s[m] = MAXV[OUT_WIDTH-1:0];
      else if (big_s[m] < MINV) res_s[m] = MINV[OUT_WIDTH-1:0];
      else                      res_s[m] = big_s[m][OUT_WIDTH-1:0];
      sat_s[OUT_WIDTH*m +: OUT_WIDTH] = (RELU_ON && res_s[m][OUT_WIDTH-1]) ?
                                        {OUT_WIDTH{1'b0}} : res_s[m];
    end
  end

  // Valid/last pipeline and output register; a load kills everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v0_r, v1_r, v2_r, l0_r, l1_r, l2_r} <= 6'b000000;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      out_r        <= {(OUT_WIDTH*MAPS){1'b0}};
    end else if (load) begin
      {v0_r, v1_r, v2_r, l0_r, l1_r, l2_r} <= 6'b000000;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      v0_r         <= wv_s;
      l0_r         <= wv_s & wl_s;
      v1_r         <= v0_r;
      l1_r         <= l0_r;
      v2_r         <= v1_r;
      l2_r         <= l1_r;
      out_valid_r  <= v2_r;
      frame_done_r <= l2_r;
      if (v2_r) out_r <= sat_s;
    end
  end

  assign ready      = ready_r;
  assign out        = out_r;
  assign out_valid  = out_valid_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_conv_layer_stream.sv
// Scoreboard bench: instance a (stride 1, ReLU, 32-bit) and instance b (stride 2, no ReLU,
// 16-bit) share one stimulus stream; expectations come from a direct convolution of the image.
module tb_conv_layer_stream;
  localparam int MAPS = 6;
  localparam int K    = 5;
  localparam int KK   = 25;
  localparam int IW   = 32;
  localparam int IH   = 32;

  logic clk = 1'b0, rst = 1'b1, load = 1'b0, en = 1'b0;
  logic signed [7:0] load_data = 8'sd0, pix = 8'sd0;
  logic ready_a, ova, fda, ready_b, ovb, fdb;
  logic [32*MAPS-1:0] out_a;
  logic [16*MAPS-1:0] out_b;

  always #5 clk = ~clk;

  conv_layer_stream #(.OUT_WIDTH(32), .STRIDE(1), .RELU(1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data), .en(en), .in(pix),
    .ready(ready_a), .out(out_a), .out_valid(ova), .frame_done(fda));

  conv_layer_stream #(.OUT_WIDTH(16), .STRIDE(2), .RELU(0)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data), .en(en), .in(pix),
    .ready(ready_b), .out(out_b), .out_valid(ovb), .frame_done(fdb));

  typedef struct packed {
    logic [32*MAPS-1:0] v;
    logic [31:0]        cyc;
    logic               last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int vectors = 0, miscompares = 0;
  int cyc = 0, cnt_a = 0, cnt_b = 0, fd_a = 0, fd_b = 0;
  int a0, b0, fa0, fb0;
  int kw[MAPS][KK];
  int kb[MAPS];
  int img[IH][IW];
  int br = 0, bc = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input int r, input int c, input int m, input int ow, input bit relu);
    longint s, mx, mn;
    s = kb[m];
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        s += longint'(img[r-K+1+ky][c-K+1+kx]) * longint'(kw[m][ky*K+kx]);
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -mx - 1;
    if (s > mx) s = mx;
    else if (s < mn) s = mn;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  function automatic exp_t mk(input int r, input int c, input int ow, input bit relu, input bit last);
    exp_t e;
    e.v = '0;
    for (int m = 0; m < MAPS; m++) e.v[32*m +: 32] = 32'(model(r, c, m, ow, relu));
    e.cyc  = 32'(cyc + 4);
    e.last = last;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare on every pulse, including timing and frame_done
  always @(negedge clk) begin
    if (!rst) begin
      if (ova) begin
        cnt_a++;
        if (fda) fd_a++;
        if (qa.size() == 0) check_val("a_unexpected_pulse", 1, 0);
        else begin
          ea = qa.pop_front();
          for (int m = 0; m < MAPS; m++)
            check_val($sformatf("a_map%0d", m), $signed(out_a[32*m +: 32]), $signed(ea.v[32*m +: 32]));
          check_val("a_latency", cyc, longint'(ea.cyc));
          check_val("a_frame_done", fda, ea.last);
        end
      end else check_val("a_fd_idle", fda, 0);
      if (ovb) begin
        cnt_b++;
        if (fdb) fd_b++;
        if (qb.size() == 0) check_val("b_unexpected_pulse", 1, 0);
        else begin
          eb = qb.pop_front();
          for (int m = 0; m < MAPS; m++)
            check_val($sformatf("b_map%0d", m), $signed(out_b[16*m +: 16]), $signed(eb.v[32*m +: 32]));
          check_val("b_latency", cyc, longint'(eb.cyc));
          check_val("b_frame_done", fdb, eb.last);
        end
      end else check_val("b_fd_idle", fdb, 0);
    end
  end

  task automatic flush();
    while (qa.size() > 0 && qa[$].cyc > 32'(cyc)) void'(qa.pop_back());
    while (qb.size() > 0 && qb[$].cyc > 32'(cyc)) void'(qb.pop_back());
  endtask

  task automatic set_img(input bit ramp, input int val);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = ramp ? ((r + c) % 128) : val;
  endtask

  task automatic load_kernel();
    int n, m, i;
    n = MAPS * (KK + 1);
    for (int w = 0; w < n; w++) begin
      @(negedge clk);
      if (w == 0) flush();
      if (w == 1 || w == n - 1) begin
        check_val("ready_a_loading", ready_a, 0);
        check_val("ready_b_loading", ready_b, 0);
      end
      m = w / (KK + 1);
      i = w % (KK + 1);
      load = 1'b1;
      load_data = 8'((i < KK) ? kw[m][i] : kb[m]);
      en = 1'b1;
      pix = 8'($urandom_range(255, 0));
    end
    @(negedge clk);
    load = 1'b0;
    en = 1'b0;
    check_val("ready_a_loaded", ready_a, 1);
    check_val("ready_b_loaded", ready_b, 1);
    br = 0;
    bc = 0;
  endtask

  task automatic drive_px(input bit gaps);
    if (gaps) begin
      while ($urandom_range(1, 0) == 0) begin
        @(negedge clk);
        en = 1'b0;
      end
    end
    @(negedge clk);
    en = 1'b1;
    pix = 8'(img[br][bc]);
    if (br >= K - 1 && bc >= K - 1) begin
      qa.push_back(mk(br, bc, 32, 1'b1, br == 31 && bc == 31));
      if ((br - 4) % 2 == 0 && (bc - 4) % 2 == 0)
        qb.push_back(mk(br, bc, 16, 1'b0, br == 30 && bc == 30));
    end
    if (bc == IW - 1) begin
      bc = 0;
      br = (br == IH - 1) ? 0 : br + 1;
    end else bc++;
  endtask

  task automatic drain();
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 12 && (qa.size() + qb.size()) > 0; i++) @(negedge clk);
    check_val("drain_a", qa.size(), 0);
    check_val("drain_b", qb.size(), 0);
  endtask

  task automatic snap();
    a0 = cnt_a; b0 = cnt_b; fa0 = fd_a; fb0 = fd_b;
  endtask

  task automatic frame(input bit gaps);
    snap();
    for (int p = 0; p < IW * IH; p++) drive_px(gaps);
    drain();
    check_val("pulses_a", cnt_a - a0, 784);
    check_val("pulses_b", cnt_b - b0, 196);
    check_val("frames_a", fd_a - fa0, 1);
    check_val("frames_b", fd_b - fb0, 1);
  endtask

  task automatic ones_kernel(input int wv, input int bv);
    for (int m = 0; m < MAPS; m++) begin
      kb[m] = bv;
      for (int i = 0; i < KK; i++) kw[m][i] = wv;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_ready_a", ready_a, 0);
    check_val("rst_ready_b", ready_b, 0);
    check_val("rst_valid_a", ova, 0);
    check_val("rst_done_a", fda, 0);
    check_val("rst_out_a", longint'(|out_a), 0);
    check_val("rst_out_b", longint'(|out_b), 0);
    rst = 1'b0;

    // All-ones kernel and image: 25 everywhere
    ones_kernel(1, 0);
    load_kernel();
    set_img(1'b0, 1);
    frame(1'b0);

    // Delta / bias-only / mixed kernels on the ramp image, continuous then gapped
    ones_kernel(0, 0);
    kw[0][12] = 1;
    kb[1] = -3;
    for (int m = 2; m < MAPS; m++) begin
      kb[m] = m;
      for (int i = 0; i < KK; i++) kw[m][i] = ((i + m) % 3) - 1;
    end
    load_kernel();
    set_img(1'b1, 0);
    frame(1'b0);
    frame(1'b1);

    // Saturation: 403352 fits 32 bits, clips to 32767 at 16 bits
    ones_kernel(127, 127);
    load_kernel();
    set_img(1'b0, 127);
    frame(1'b0);

    // Reset mid-frame at row 10
    ones_kernel(1, 0);
    load_kernel();
    set_img(1'b0, 1);
    for (int p = 0; p < 10 * IW + 5; p++) drive_px(1'b0);
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    flush();
    repeat (3) @(negedge clk);
    check_val("abort_rst_ready_a", ready_a, 0);
    check_val("abort_rst_ready_b", ready_b, 0);
    check_val("abort_rst_valid_a", ova, 0);
    #2 rst = 1'b0;
    snap();
    repeat (8) @(negedge clk);
    check_val("abort_rst_quiet_a", cnt_a - a0, 0);
    check_val("abort_rst_quiet_b", cnt_b - b0, 0);
    check_val("abort_rst_ready_after", ready_a, 0);
    load_kernel();
    frame(1'b0);

    // Load mid-frame: a new asymmetric kernel proves the index restarted at word 0
    for (int p = 0; p < 10 * IW + 10; p++) drive_px(1'b0);
    for (int m = 0; m < MAPS; m++) begin
      kb[m] = 5 * m - 7;
      for (int i = 0; i < KK; i++) kw[m][i] = (m == 0) ? (i - 12) : (((m * 7 + i) % 5) - 2);
    end
    load_kernel();
    set_img(1'b1, 0);
    frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
